// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response port of the load/store unit plus its
// connection to the data memory (data_add / Data_in / en_write / data_out).
// slave  = the load/store unit, master = the execute stage / memory side.
interface load_store_unit_if;
  // request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // data memory
  logic [31:0] mem_add;
  logic [31:0] mem_data_out;
  logic        mem_en_write;
  logic [31:0] mem_data_in;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_add, mem_data_out, mem_en_write,
    input  mem_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_add, mem_data_out, mem_en_write,
    output mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one byte/halfword/word access at a time between execute
// and the data memory. Byte addresses become word indices, sub-word stores
// are done as read-modify-write, loads are sign/zero extended.
// The memory samples on the falling edge; everything here is rising-edge.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned halfword
// and word accesses (otherwise the low address bits are simply ignored).
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 65534
) (
  input  logic        clk,
  input  logic        rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state;
  logic [1:0]  lane_q;    // addr[1:0] of the accepted request
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [15:0] wdata_q;   // only the sub-word store path needs the data later

  logic [31:0] word_idx;
  logic        range_err;
  logic        align_err;
  logic        acc_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;

  assign bus.req_ready = (state == IDLE) & ~rst;

  assign word_idx  = {2'b00, bus.req_addr[31:2]};
  assign range_err = (word_idx >= MEM_WORDS);

`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = ((bus.req_size == 2'b01) &&  bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign acc_err = range_err | align_err | (bus.req_size == 2'b11);

  // Lane extraction and sign/zero extension of the word read in RD
  always_comb begin
    ld_byte = bus.mem_data_in[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
    ld_ext  = bus.mem_data_in;
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_data_in;
    endcase
  end

  // Merge of the store bytes into the word read in RD; other bytes untouched
  always_comb begin
    st_merge = bus.mem_data_in;
    case (size_q)
      2'b00: st_merge[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane_q[1]) st_merge[31:16] = wdata_q;
        else           st_merge[15:0]  = wdata_q;
      end
      default: st_merge = bus.mem_data_in;
    endcase
  end

  // Access sequencer with registered memory and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      lane_q           <= '0;
      size_q           <= '0;
      signed_q         <= 1'b0;
      write_q          <= 1'b0;
      wdata_q          <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_err     <= 1'b0;
      bus.mem_add      <= '0;
      bus.mem_data_out <= '0;
      bus.mem_en_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_en_write <= 1'b0;
          bus.resp_valid   <= 1'b0;
          bus.resp_err     <= 1'b0;
          bus.resp_rdata   <= '0;
          if (bus.req_valid) begin
            lane_q   <= bus.req_addr[1:0];
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
            wdata_q  <= bus.req_wdata[15:0];
            if (acc_err) begin
              // rejected: straight to the response, memory never touched
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              state          <= RSP;
            end else if (bus.req_write && (bus.req_size == 2'b10)) begin
              bus.mem_add      <= word_idx;
              bus.mem_data_out <= bus.req_wdata;
              bus.mem_en_write <= 1'b1;
              state            <= WR;
            end else begin
              // loads and sub-word stores both start with a read
              bus.mem_add <= word_idx;
              state       <= RD;
            end
          end
        end
        RD: begin
          if (write_q) begin
            bus.mem_data_out <= st_merge;
            bus.mem_en_write <= 1'b1;
            state            <= WR;
          end else begin
            bus.resp_rdata <= ld_ext;
            bus.resp_valid <= 1'b1;
            state          <= RSP;
          end
        end
        WR: begin
          bus.mem_en_write <= 1'b0;
          bus.resp_valid   <= 1'b1;
          bus.resp_rdata   <= '0;
          state            <= RSP;
        end
        default: begin  // RSP
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
